// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALU control codes, ALUOp encodings, funct values, EX bus bit indices.
// Shift codes exist only when SEG_EXECUTE_SHIFT_EN is defined.
package mips_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLTU    = 4'b1000;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    localparam logic [1:0] ALUOP_LWSW   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

`ifdef SEG_EXECUTE_SHIFT_EN
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;
`endif

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/seg_execute_alu_ctrl.sv
// ALU control decoder: ALUOp plus funct to internal ALU control code (combinational).
// SEG_EXECUTE_SHIFT_EN adds the SLL/SRL/SRA funct decodes.
module seg_execute_alu_ctrl
    import mips_pkg::*;
#(
    parameter int NB_ALUOP  = 2,
    parameter int NB_ALUCTL = 4,
    parameter int NB_FUNC   = 6
) (
    input  logic [NB_ALUOP-1:0]  i_alu_op,
    input  logic [NB_FUNC-1:0]   i_funct,
    output logic [NB_ALUCTL-1:0] o_alu_ctl
);

    // Decode ALUOp first; only R-type consults funct.
    always_comb begin
        o_alu_ctl = NB_ALUCTL'(ALU_INVALID);
        case (i_alu_op)
            ALUOP_LWSW,
            ALUOP_IMM:    o_alu_ctl = NB_ALUCTL'(ALU_ADD);
            ALUOP_BRANCH: o_alu_ctl = NB_ALUCTL'(ALU_SUB);
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD,
                    FUNCT_ADDU: o_alu_ctl = NB_ALUCTL'(ALU_ADD);
                    FUNCT_SUB,
                    FUNCT_SUBU: o_alu_ctl = NB_ALUCTL'(ALU_SUB);
                    FUNCT_AND:  o_alu_ctl = NB_ALUCTL'(ALU_AND);
                    FUNCT_OR:   o_alu_ctl = NB_ALUCTL'(ALU_OR);
                    FUNCT_XOR:  o_alu_ctl = NB_ALUCTL'(ALU_XOR);
                    FUNCT_NOR:  o_alu_ctl = NB_ALUCTL'(ALU_NOR);
                    FUNCT_SLT:  o_alu_ctl = NB_ALUCTL'(ALU_SLT);
                    FUNCT_SLTU: o_alu_ctl = NB_ALUCTL'(ALU_SLTU);
`ifdef SEG_EXECUTE_SHIFT_EN
                    FUNCT_SLL:  o_alu_ctl = NB_ALUCTL'(ALU_SLL);
                    FUNCT_SRL:  o_alu_ctl = NB_ALUCTL'(ALU_SRL);
                    FUNCT_SRA:  o_alu_ctl = NB_ALUCTL'(ALU_SRA);
`endif
                    default:    o_alu_ctl = NB_ALUCTL'(ALU_INVALID);
                endcase
            end
            default:      o_alu_ctl = NB_ALUCTL'(ALU_INVALID);
        endcase
    end

endmodule

// File: rtl/seg_execute.sv
// MIPS EX stage with EX/MEM pipeline register: ALU, zero flag, branch target, destination select.
// Define SEG_EXECUTE_SHIFT_EN to enable SLL/SRL/SRA on operand B by instruction[10:6].
module seg_execute
    import mips_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int NB_ALUOP   = 2,
    parameter int NB_ALUCTL  = 4,
    parameter int NB_ADDR    = 5,
    parameter int NB_FUNC    = 6,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_CTRL_M  = 3,
    parameter int NB_CTRL_EX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [LEN-1:0]        i_PC,
    input  logic [LEN-1:0]        i_read_data_1,
    input  logic [LEN-1:0]        i_read_data_2,
    input  logic [LEN-1:0]        i_addr_ext,
    input  logic [NB_ADDR-1:0]    i_rt,
    input  logic [NB_ADDR-1:0]    i_rd,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
    output logic [LEN-1:0]        o_PC_branch,
    output logic [LEN-1:0]        o_ALU_result,
    output logic [LEN-1:0]        o_write_data,
    output logic [NB_ADDR-1:0]    o_write_register,
    output logic                  o_ALU_zero,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus
);

    logic [NB_ALUCTL-1:0] alu_ctl_s;
    logic [NB_ALUOP-1:0]  alu_op_s;
    logic [LEN-1:0]       op_a_s;
    logic [LEN-1:0]       op_b_s;
    logic [LEN-1:0]       alu_res_s;
`ifdef SEG_EXECUTE_SHIFT_EN
    logic [4:0]           shamt_s;
    assign shamt_s = i_addr_ext[10:6];
`endif

    logic [LEN-1:0]        pc_branch_d,  pc_branch_q;
    logic [LEN-1:0]        alu_result_d, alu_result_q;
    logic [LEN-1:0]        write_data_d, write_data_q;
    logic [NB_ADDR-1:0]    write_reg_d,  write_reg_q;
    logic                  alu_zero_d,   alu_zero_q;
    logic [NB_CTRL_WB-1:0] ctrl_wb_d,    ctrl_wb_q;
    logic [NB_CTRL_M-1:0]  ctrl_mem_d,   ctrl_mem_q;

    assign alu_op_s = i_ctrl_exc_bus[EX_ALUOP_HI:EX_ALUOP_LO];
    assign op_a_s   = i_read_data_1;
    assign op_b_s   = i_ctrl_exc_bus[EX_ALUSRC] ? i_addr_ext : i_read_data_2;

    seg_execute_alu_ctrl #(
        .NB_ALUOP  (NB_ALUOP),
        .NB_ALUCTL (NB_ALUCTL),
        .NB_FUNC   (NB_FUNC)
    ) u_alu_ctrl (
        .i_alu_op  (alu_op_s),
        .i_funct   (i_addr_ext[NB_FUNC-1:0]),
        .o_alu_ctl (alu_ctl_s)
    );

    // ALU datapath; arithmetic wraps, invalid codes produce zero.
    always_comb begin
        alu_res_s = {LEN{1'b0}};
        case (alu_ctl_s)
            NB_ALUCTL'(ALU_AND):  alu_res_s = op_a_s & op_b_s;
            NB_ALUCTL'(ALU_OR):   alu_res_s = op_a_s | op_b_s;
            NB_ALUCTL'(ALU_ADD):  alu_res_s = op_a_s + op_b_s;
            NB_ALUCTL'(ALU_XOR):  alu_res_s = op_a_s ^ op_b_s;
            NB_ALUCTL'(ALU_SUB):  alu_res_s = op_a_s - op_b_s;
            NB_ALUCTL'(ALU_SLT):  alu_res_s = {{(LEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            NB_ALUCTL'(ALU_SLTU): alu_res_s = {{(LEN-1){1'b0}}, (op_a_s < op_b_s)};
            NB_ALUCTL'(ALU_NOR):  alu_res_s = ~(op_a_s | op_b_s);
`ifdef SEG_EXECUTE_SHIFT_EN
            NB_ALUCTL'(ALU_SLL):  alu_res_s = op_b_s << shamt_s;
            NB_ALUCTL'(ALU_SRL):  alu_res_s = op_b_s >> shamt_s;
            NB_ALUCTL'(ALU_SRA):  alu_res_s = LEN'($signed(op_b_s) >>> shamt_s);
`endif
            default:              alu_res_s = {LEN{1'b0}};
        endcase
    end

    assign alu_result_d = alu_res_s;
    assign alu_zero_d   = (alu_res_s == {LEN{1'b0}});
    assign pc_branch_d  = i_PC + {i_addr_ext[LEN-3:0], 2'b00};
    assign write_reg_d  = i_ctrl_exc_bus[EX_REGDST] ? i_rd : i_rt;
    assign write_data_d = i_read_data_2;
    assign ctrl_wb_d    = i_ctrl_wb_bus;
    assign ctrl_mem_d   = i_ctrl_mem_bus;

    // EX/MEM pipeline register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_branch_q  <= {LEN{1'b0}};
            alu_result_q <= {LEN{1'b0}};
            write_data_q <= {LEN{1'b0}};
            write_reg_q  <= {NB_ADDR{1'b0}};
            alu_zero_q   <= 1'b0;
            ctrl_wb_q    <= {NB_CTRL_WB{1'b0}};
            ctrl_mem_q   <= {NB_CTRL_M{1'b0}};
        end else begin
            pc_branch_q  <= pc_branch_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            alu_zero_q   <= alu_zero_d;
            ctrl_wb_q    <= ctrl_wb_d;
            ctrl_mem_q   <= ctrl_mem_d;
        end
    end

    assign o_PC_branch      = pc_branch_q;
    assign o_ALU_result     = alu_result_q;
    assign o_write_data     = write_data_q;
    assign o_write_register = write_reg_q;
    assign o_ALU_zero       = alu_zero_q;
    assign o_ctrl_wb_bus    = ctrl_wb_q;
    assign o_ctrl_mem_bus   = ctrl_mem_q;

endmodule

// File: tb/tb_seg_execute.sv
// Self-checking bench for seg_execute: directed cases plus randomized stimulus against a behavioural model.
module tb_seg_execute;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_PC, i_read_data_1, i_read_data_2, i_addr_ext;
    logic [4:0]  i_rt, i_rd;
    logic [1:0]  i_ctrl_wb_bus;
    logic [2:0]  i_ctrl_mem_bus;
    logic [3:0]  i_ctrl_exc_bus;
    logic [31:0] o_PC_branch, o_ALU_result, o_write_data;
    logic [4:0]  o_write_register;
    logic        o_ALU_zero;
    logic [1:0]  o_ctrl_wb_bus;
    logic [2:0]  o_ctrl_mem_bus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] e_pc, e_res, e_wd;
    logic [4:0]  e_wr;
    logic        e_zero;
    logic [1:0]  e_wb;
    logic [2:0]  e_mem;

    seg_execute dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_PC             (i_PC),
        .i_read_data_1    (i_read_data_1),
        .i_read_data_2    (i_read_data_2),
        .i_addr_ext       (i_addr_ext),
        .i_rt             (i_rt),
        .i_rd             (i_rd),
        .i_ctrl_wb_bus    (i_ctrl_wb_bus),
        .i_ctrl_mem_bus   (i_ctrl_mem_bus),
        .i_ctrl_exc_bus   (i_ctrl_exc_bus),
        .o_PC_branch      (o_PC_branch),
        .o_ALU_result     (o_ALU_result),
        .o_write_data     (o_write_data),
        .o_write_register (o_write_register),
        .o_ALU_zero       (o_ALU_zero),
        .o_ctrl_wb_bus    (o_ctrl_wb_bus),
        .o_ctrl_mem_bus   (o_ctrl_mem_bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // MIPS EX semantics from the instruction set view: what the instruction computes.
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ext);
        logic [5:0] f;
        int sh;
        f  = ext[5:0];
        sh = int'(ext[10:6]);
        if (op == 2'd0 || op == 2'd3) return a + b;
        if (op == 2'd1) return a - b;
        case (f)
            6'd32, 6'd33: return a + b;
            6'd34, 6'd35: return a - b;
            6'd36: return a & b;
            6'd37: return a | b;
            6'd38: return a ^ b;
            6'd39: return ~(a | b);
            6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd43: return (a < b) ? 32'd1 : 32'd0;
`ifdef SEG_EXECUTE_SHIFT_EN
            6'd0:  return b << sh;
            6'd2:  return b >> sh;
            6'd3:  return 32'($signed(b) >>> sh);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pcb"},  o_PC_branch, e_pc);
        chk({tag, ".res"},  o_ALU_result, e_res);
        chk({tag, ".wd"},   o_write_data, e_wd);
        chk({tag, ".wr"},   32'(o_write_register), 32'(e_wr));
        chk({tag, ".zero"}, 32'(o_ALU_zero), 32'(e_zero));
        chk({tag, ".wb"},   32'(o_ctrl_wb_bus), 32'(e_wb));
        chk({tag, ".mem"},  32'(o_ctrl_mem_bus), 32'(e_mem));
    endtask

    task automatic clear_exp();
        e_pc = 32'd0; e_res = 32'd0; e_wd = 32'd0; e_wr = 5'd0;
        e_zero = 1'b0; e_wb = 2'd0; e_mem = 3'd0;
    endtask

    // Called just after a rising edge: apply inputs, confirm outputs hold, then check after the edge.
    task automatic drive(input string tag, input logic [31:0] pc, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] ext, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [1:0] wb, input logic [2:0] mem,
                         input logic [3:0] exc);
        logic [31:0] b;
        i_PC = pc; i_read_data_1 = rd1; i_read_data_2 = rd2; i_addr_ext = ext;
        i_rt = rt; i_rd = rd; i_ctrl_wb_bus = wb; i_ctrl_mem_bus = mem; i_ctrl_exc_bus = exc;
        #1;
        chk({tag, ".hold_res"}, o_ALU_result, e_res);
        chk({tag, ".hold_wb"},  32'(o_ctrl_wb_bus), 32'(e_wb));
        b      = exc[0] ? ext : rd2;
        e_res  = ref_alu(exc[2:1], rd1, b, ext);
        e_zero = (e_res == 32'd0);
        e_pc   = pc + ext * 32'd4;
        e_wr   = exc[3] ? rd : rt;
        e_wd   = rd2;
        e_wb   = wb;
        e_mem  = mem;
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    logic [5:0] functs [0:13] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
                                  6'd39, 6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd44};

    initial begin
        logic [31:0] ext;
        i_rst = 1'b0;
        clear_exp();
        for (int k = 0; k < 3; k++) begin
            i_PC = $urandom; i_read_data_1 = $urandom; i_read_data_2 = $urandom;
            i_addr_ext = $urandom; i_rt = 5'($urandom); i_rd = 5'($urandom);
            i_ctrl_wb_bus = 2'($urandom); i_ctrl_mem_bus = 3'($urandom);
            i_ctrl_exc_bus = 4'($urandom);
            @(posedge i_clk);
            #1;
            check_all("reset");
        end
        i_rst = 1'b1;

        drive("ls", 32'h0, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd9, 5'd17, 2'd1, 3'd2, 4'b0001);
        chk("ls_lit_res", o_ALU_result, 32'hFC);
        chk("ls_lit_wr", 32'(o_write_register), 32'd9);
        chk("ls_lit_wd", o_write_data, 32'hDEADBEEF);
        drive("br", 32'h40, 32'h1234, 32'h1234, 32'h3, 5'd1, 5'd2, 2'd0, 3'd0, 4'b0010);
        chk("br_lit_zero", 32'(o_ALU_zero), 32'd1);
        chk("br_lit_pcb", o_PC_branch, 32'h4C);
        drive("brneg", 32'h40, 32'h1234, 32'h1234, 32'hFFFFFFFF, 5'd1, 5'd2, 2'd0, 3'd0, 4'b0010);
        chk("brneg_lit_pcb", o_PC_branch, 32'h3C);

        drive("radd", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd32, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("radd_lit", o_ALU_result, 32'hFFFFFFFF);
        chk("r_lit_wr", 32'(o_write_register), 32'd4);
        drive("rand", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd36, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rand_lit", o_ALU_result, 32'h0);
        drive("ror", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd37, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("ror_lit", o_ALU_result, 32'hFFFFFFFF);
        drive("rxor", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd38, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rxor_lit", o_ALU_result, 32'hFFFFFFFF);
        drive("rnor", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd39, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rnor_lit", o_ALU_result, 32'h0);
        drive("rslt", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd42, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rslt_lit", o_ALU_result, 32'h1);
        drive("rsltu", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd43, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rsltu_lit", o_ALU_result, 32'h0);
        drive("rinv", 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd44, 5'd3, 5'd4, 2'd0, 3'd0, 4'b1100);
        chk("rinv_lit_res", o_ALU_result, 32'h0);
        chk("rinv_lit_zero", 32'(o_ALU_zero), 32'd1);
        drive("imm", 32'h0, 32'd5, 32'd99, 32'd7, 5'd3, 5'd4, 2'd0, 3'd0, 4'b0111);
        chk("imm_lit", o_ALU_result, 32'd12);

        drive("pass", 32'h0, 32'h7FFFFFFF, 32'h1, 32'd32, 5'd3, 5'd4, 2'b10, 3'b101, 4'b1100);
        chk("pass_lit_wb", 32'(o_ctrl_wb_bus), 32'h2);
        chk("pass_lit_mem", 32'(o_ctrl_mem_bus), 32'h5);
        chk("wrap_lit", o_ALU_result, 32'h80000000);
        drive("pass2", 32'h0, 32'h1, 32'h1, 32'd34, 5'd3, 5'd4, 2'b01, 3'b010, 4'b1100);

        for (int k = 0; k < 300; k++) begin
            ext = $urandom;
            if ($urandom_range(3, 0) != 0) ext[5:0] = functs[$urandom_range(13, 0)];
            drive("rnd", $urandom, ($urandom_range(7, 0) == 0) ? 32'h80000000 : $urandom,
                  $urandom, ext, 5'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                  4'($urandom));
        end

        #2;
        i_rst = 1'b0;
        #1;
        clear_exp();
        check_all("midrst");
        @(posedge i_clk);
        #1;
        check_all("midrst_hold");
        i_rst = 1'b1;
        drive("post", 32'h100, 32'd20, 32'd8, 32'd34, 5'd7, 5'd8, 2'd3, 3'd7, 4'b1100);
        chk("post_lit_res", o_ALU_result, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
